// File: rtl/dmem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_mmio                                                       |
// | Purpose  : Data-side memory responder for the core's M-stage port. Word    |
// |            RAM plus a 256-byte peripheral page holding an LED register, a  |
// |            free-running cycle counter and a byte TX FIFO drained over a    |
// |            valid/ready handshake. Load data is returned combinationally.   |
// | Ports    : clk, rst (sync, active-high)                                    |
// |            addr[31:0], wdata[31:0], we  - core request                     |
// |            rdata[31:0]                  - load data (combinational)        |
// |            led[15:0]                    - LED register                     |
// |            tx_data[7:0], tx_valid, tx_ready - FIFO drain port              |
// |            bus_err                      - sticky unmapped-access flag      |
// | Options  : DMEM_MMIO_BUSERR_EN - enables the bus_err flag; when undefined  |
// |            bus_err is tied 0 and STATUS[3] reads 0.                        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_mmio #(
  parameter int unsigned WORDS      = 64,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic [15:0] led,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int unsigned     c_aw        = $clog2(WORDS);
  localparam int unsigned     c_pw        = $clog2(FIFO_DEPTH);
  localparam int unsigned     c_cw        = c_pw + 1;
  localparam logic [c_cw-1:0] c_full      = c_cw'(FIFO_DEPTH);
  localparam logic [31:0]     c_ram_bytes = 32'(WORDS * 4);
  localparam logic [5:0]      c_off_led    = 6'h00;
  localparam logic [5:0]      c_off_cycle  = 6'h01;
  localparam logic [5:0]      c_off_txdata = 6'h02;
  localparam logic [5:0]      c_off_status = 6'h03;

  // Address decode (byte lanes ignored: word accesses only)
  logic            is_ram;
  logic            is_mmio;
  logic [c_aw-1:0] ram_idx;
  logic [5:0]      mmio_off;

  assign is_ram   = addr < c_ram_bytes;
  assign is_mmio  = !is_ram && (addr[31:8] == MMIO_BASE[31:8]);
  assign ram_idx  = addr[c_aw+1:2];
  assign mmio_off = addr[7:2];

  logic led_wr;
  logic push_req;
  logic status_wr;

  assign led_wr    = we && is_mmio && (mmio_off == c_off_led);
  assign push_req  = we && is_mmio && (mmio_off == c_off_txdata);
  assign status_wr = we && is_mmio && (mmio_off == c_off_status);

  // State
  logic [15:0]     led_q,    led_d;
  logic [31:0]     cycle_q,  cycle_d;
  logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_cw-1:0] count_q,  count_d;
  logic            ovf_q,    ovf_d;

  logic [31:0] mem_q  [WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == c_full);
  assign pop        = !fifo_empty && tx_ready;
  // A push into a full FIFO is still accepted when the head leaves in the same cycle.
  assign push       = push_req && (!fifo_full || pop);

  // Storage arrays: no reset; FIFO contents become unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (we && is_ram) begin
      mem_q[ram_idx] <= wdata;
    end
    if (push) begin
      fifo_q[wr_ptr_q] <= wdata[7:0];
    end
  end

  always_comb begin
    led_d    = led_q;
    cycle_d  = cycle_q + 32'd1;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (led_wr) begin
      led_d = wdata[15:0];
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_pw'(1);
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + c_pw'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase
    // Clear first so a simultaneous set wins.
    if (status_wr && wdata[2]) begin
      ovf_d = 1'b0;
    end
    if (push_req && fifo_full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led_q    <= 16'd0;
      cycle_q  <= 32'd0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      led_q    <= led_d;
      cycle_q  <= cycle_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef DMEM_MMIO_BUSERR_EN
  logic bus_err_q, bus_err_d;

  // Stores to unmapped space always flag; loads flag unless addr is 0,
  // which is how an idle core port presents itself.
  always_comb begin
    bus_err_d = bus_err_q;
    if (status_wr && wdata[3]) begin
      bus_err_d = 1'b0;
    end
    if (!is_ram && !is_mmio && (we || (addr != 32'd0))) begin
      bus_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Load path: pure function of addr and current state.
  always_comb begin
    rdata = 32'd0;
    if (is_ram) begin
      rdata = mem_q[ram_idx];
    end else if (is_mmio) begin
      case (mmio_off)
        c_off_led:    rdata = {16'd0, led_q};
        c_off_cycle:  rdata = cycle_q;
        c_off_status: rdata = {19'd0, 5'(count_q), 4'd0, bus_err, ovf_q, fifo_full, fifo_empty};
        default:      rdata = 32'd0;
      endcase
    end
  end

  assign led      = led_q;
  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_mmio                                                    |
// | Purpose  : Self-checking bench for dmem_mmio. A transaction-level model    |
// |            (RAM array, byte queue, counters) predicts every output each    |
// |            cycle; directed vectors carry hand-computed literal values.     |
// | Options  : DMEM_MMIO_BUSERR_EN - must match the RTL build.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_mmio;

`ifdef DMEM_MMIO_BUSERR_EN
  localparam bit c_be = 1'b1;
`else
  localparam bit c_be = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  dmem_mmio dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .led      (led),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_err  (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  m_ram   [64];
  bit           m_known [64];
  logic [15:0]  m_led;
  logic [31:0]  m_cyc;
  byte unsigned m_q[$];
  bit           m_ovf;
  bit           m_berr;
  bit           m_ok = 1'b0;

  task automatic model_step();
    bit mm;
    bit unm;
    bit pop;
    bit full;
    mm   = (addr[31:8] == 24'hFFFFFF);
    unm  = !(addr < 32'd256) && !mm;
    pop  = (m_q.size() != 0) && tx_ready;
    full = (m_q.size() == 8);
    if (we && addr < 32'd256) begin
      m_ram[addr[7:2]]   = wdata;
      m_known[addr[7:2]] = 1'b1;
    end
    if (rst) begin
      m_led  = 16'd0;
      m_cyc  = 32'd0;
      m_q.delete();
      m_ovf  = 1'b0;
      m_berr = 1'b0;
      m_ok   = 1'b1;
    end else if (m_ok) begin
      m_cyc = m_cyc + 32'd1;
      if (we && mm && addr[7:2] == 6'd0) m_led = wdata[15:0];
      if (we && mm && addr[7:2] == 6'd3) begin
        if (wdata[2]) m_ovf = 1'b0;
        if (wdata[3]) m_berr = 1'b0;
      end
      if (pop) void'(m_q.pop_front());
      if (we && mm && addr[7:2] == 6'd2) begin
        if (full && !pop) m_ovf = 1'b1;
        else m_q.push_back(wdata[7:0]);
      end
      if (c_be && unm && (we || addr != 32'd0)) m_berr = 1'b1;
    end
  endtask

  // Compare process: checks just before each rising edge, then advances the model.
  initial begin
    logic [31:0] exp;
    bit          known;
    forever begin
      @(negedge clk);
      #4;
      if (m_ok) begin
        exp   = 32'd0;
        known = 1'b1;
        if (addr < 32'd256) begin
          known = m_known[addr[7:2]];
          exp   = m_ram[addr[7:2]];
        end else if (addr[31:8] == 24'hFFFFFF) begin
          case (addr[7:2])
            6'd0:    exp = {16'd0, m_led};
            6'd1:    exp = m_cyc;
            6'd3:    exp = {19'd0, 5'(m_q.size()), 4'd0, m_berr, m_ovf,
                            m_q.size() == 8, m_q.size() == 0};
            default: exp = 32'd0;
          endcase
        end
        if (known) chk("m_rdata", rdata, exp);
        chk("m_led", {16'd0, led}, {16'd0, m_led});
        chk("m_tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0) chk("m_tx_data", {24'd0, tx_data}, {24'd0, m_q[0]});
        chk("m_bus_err", {31'd0, bus_err}, {31'd0, m_berr});
      end
      @(posedge clk);
      model_step();
    end
  end

  // ---------------- stimulus ----------------
  // Drives one cycle of inputs at the falling edge; returns 1 time unit before the rising edge.
  task automatic put(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic rdy);
    @(negedge clk);
    rst      = r;
    we       = w;
    addr     = a;
    wdata    = d;
    tx_ready = rdy;
    #4;
  endtask

  localparam logic [31:0] A_LED  = 32'hFFFF_FF00;
  localparam logic [31:0] A_CYC  = 32'hFFFF_FF04;
  localparam logic [31:0] A_TX   = 32'hFFFF_FF08;
  localparam logic [31:0] A_STAT = 32'hFFFF_FF0C;

  initial begin
    logic [7:0] drain_exp [8];
    rst = 1'b1; we = 1'b0; addr = 32'd0; wdata = 32'd0; tx_ready = 1'b0;

    // Reset and counter
    put(1, 0, 0, 0, 0);
    put(1, 0, 0, 0, 0);
    put(0, 0, A_CYC, 0, 0);
    chk("cycle_after_reset", rdata, 32'd0);
    put(0, 0, A_STAT, 0, 0);
    chk("status_reset", rdata, 32'h0000_0001);
    chk("led_reset", {16'd0, led}, 32'd0);
    chk("tx_valid_reset", {31'd0, tx_valid}, 32'd0);
    for (int i = 0; i < 8; i++) put(0, 0, A_LED, 0, 0);
    put(0, 0, A_CYC, 0, 0);
    chk("cycle_plus10", rdata, 32'd10);

    // RAM prefill with a known pattern
    for (int i = 0; i < 64; i++) put(0, 1, 32'(i * 4), 32'hA5A5_0000 | 32'(i), 0);

    // RAM write / read-during-write
    put(0, 1, 32'h10, 32'hDEAD_BEEF, 0);
    chk("ram_rdw_old", rdata, 32'hA5A5_0004);
    put(0, 0, 32'h10, 0, 0);
    chk("ram_read_new", rdata, 32'hDEAD_BEEF);
    put(0, 0, 32'h13, 0, 0);
    chk("ram_lowbits_ignored", rdata, 32'hDEAD_BEEF);

    // LED
    put(0, 1, A_LED, 32'h1234_ABCD, 0);
    put(0, 0, A_LED, 0, 0);
    chk("led_readback", rdata, 32'h0000_ABCD);
    chk("led_port", {16'd0, led}, 32'h0000_ABCD);
    put(0, 1, A_CYC, 32'h5555_5555, 0);

    // FIFO fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      put(0, 1, A_TX, 32'h41 + 32'(i), 0);
      if (i == 0) chk("push_to_valid_latency", {31'd0, tx_valid}, 32'd0);
    end
    put(0, 0, A_STAT, 0, 0);
    chk("status_full", rdata, 32'h0000_0802);
    chk("head_first", {24'd0, tx_data}, 32'h41);
    put(0, 1, A_TX, 32'h49, 0);
    put(0, 0, A_STAT, 0, 0);
    chk("status_overflow", rdata, 32'h0000_0806);
    for (int i = 0; i < 8; i++) begin
      put(0, 0, A_TX, 0, 1);
      chk("drain_order", {24'd0, tx_data}, 32'h41 + 32'(i));
      if (i == 0) chk("txdata_reads_zero", rdata, 32'd0);
    end
    put(0, 0, A_STAT, 0, 0);
    chk("status_drained_ovf", rdata, 32'h0000_0005);
    put(0, 1, A_STAT, 32'h4, 0);
    put(0, 0, A_STAT, 0, 0);
    chk("status_ovf_cleared", rdata, 32'h0000_0001);

    // Push and pop on a full FIFO in the same cycle
    for (int i = 0; i < 8; i++) put(0, 1, A_TX, 32'h61 + 32'(i), 0);
    put(0, 1, A_TX, 32'h5A, 1);
    chk("full_pushpop_head", {24'd0, tx_data}, 32'h61);
    put(0, 0, A_STAT, 0, 0);
    chk("full_pushpop_status", rdata, 32'h0000_0802);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h62 + 8'(i);
    drain_exp[7] = 8'h5A;
    for (int i = 0; i < 8; i++) begin
      put(0, 0, A_STAT, 0, 1);
      chk("pushpop_drain", {24'd0, tx_data}, {24'd0, drain_exp[i]});
    end
    put(0, 0, A_STAT, 0, 0);
    chk("pushpop_no_ovf", rdata, 32'h0000_0001);

    // Reset mid-drain
    for (int i = 0; i < 5; i++) put(0, 1, A_TX, 32'h71 + 32'(i), 0);
    put(0, 0, A_STAT, 0, 1);
    put(1, 0, A_STAT, 0, 1);
    chk("status_before_rst", rdata, 32'h0000_0400);
    put(0, 0, A_STAT, 0, 0);
    chk("status_after_rst", rdata, 32'h0000_0001);
    chk("led_after_rst", {16'd0, led}, 32'd0);
    chk("tx_valid_after_rst", {31'd0, tx_valid}, 32'd0);
    put(0, 0, 32'h10, 0, 0);
    chk("ram_survives_rst", rdata, 32'hDEAD_BEEF);

    // Unmapped access and bus error
    put(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("bus_err_before", {31'd0, bus_err}, 32'd0);
    put(0, 0, A_STAT, 0, 0);
    chk("bus_err_set", {31'd0, bus_err}, {31'd0, c_be});
    chk("status_bus_err", rdata, c_be ? 32'h0000_0009 : 32'h0000_0001);
    put(0, 1, A_STAT, 32'h8, 0);
    put(0, 0, A_STAT, 0, 0);
    chk("bus_err_cleared", {31'd0, bus_err}, 32'd0);
    put(0, 0, 32'h0000_1000, 0, 0);
    chk("unmapped_read_zero", rdata, 32'd0);
    put(0, 0, 32'hFFFF_FF10, 0, 0);
    chk("unlisted_offset_zero", rdata, 32'd0);
    chk("unmapped_load_flag", {31'd0, bus_err}, {31'd0, c_be});
    put(0, 0, A_LED, 0, 0);
    put(0, 0, A_LED, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
